// File: rtl/prio_seg_display_pkg.sv
// Shared constants for the debounced priority-encoder display:
// digit-slice width, blank pattern and active-low hex glyphs.
package prio_seg_display_pkg;

    localparam int DIG_W = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit 6 = segment a ... bit 0 = segment g, 0 = lit
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/prio_seg_display_if.sv
// Switch-input / display-output bundle of the priority display.
// master drives switches and clear, slave drives the display side.
interface prio_seg_display_if #(
    parameter int IN_W       = 8,
    parameter int NUM_DIGITS = 4
);
    localparam int OUT_W = $clog2(IN_W);

    logic [IN_W-1:0]         data_in;
    logic                    clear;
    logic [8*NUM_DIGITS-1:0] seg;
    logic [OUT_W-1:0]        code;
    logic                    valid;
    logic                    cap_pulse;

    modport master (
        output data_in, clear,
        input  seg, code, valid, cap_pulse
    );

    modport slave (
        input  data_in, clear,
        output seg, code, valid, cap_pulse
    );

endinterface

// File: rtl/prio_seg_display_seg7_hex_lut.sv
// 4-bit value to active-low seven-segment glyph, combinational.
module prio_seg_display_seg7_hex_lut
    import prio_seg_display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = HEX_GLYPH[val_i];

endmodule

// File: rtl/prio_seg_display.sv
// Debounced priority encoder with a shift history of captured codes
// shown on static active-low seven-segment digits, newest on digit 0.
module prio_seg_display
    import prio_seg_display_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CYC = 4,
    parameter int HOLD_CYC   = 8
) (
    input logic clk,
    input logic rst,
    prio_seg_display_if.slave bus
);

    localparam int OUT_W  = $clog2(IN_W);
    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int SEG_W  = DIG_W * NUM_DIGITS;

    function automatic logic [OUT_W-1:0] prio_enc(input logic [IN_W-1:0] v);
        prio_enc = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (v[i]) prio_enc = OUT_W'(i);
        end
    endfunction

    logic [IN_W-1:0] sync1_q, sync_q;
    logic [IN_W-1:0] prev_q, prev_d;
    logic [IN_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][OUT_W-1:0] hist_q, hist_d;
    logic [NUM_DIGITS-1:0] hist_v_q, hist_v_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [OUT_W-1:0] code_q, code_d;
    logic valid_q, valid_d;
    logic cap_q, cap_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    logic accept;
    logic push;
    logic [OUT_W-1:0] enc;
    logic [6:0] glyph [NUM_DIGITS];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        prio_seg_display_seg7_hex_lut u_lut (
            .val_i   (4'(hist_q[k])),
            .glyph_o (glyph[k])
        );
    end

    // One accept per settled value; a glitch back to acc is ignored
    assign accept = (sync_q == prev_q)
                  && (cnt_q == CNT_W'(STABLE_CYC - 1))
                  && (sync_q != acc_q);
    assign push   = accept && (|sync_q) && !bus.clear;
    assign enc    = prio_enc(sync_q);

    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        code_d   = code_q;
        valid_d  = valid_q;
        hist_d   = hist_q;
        hist_v_d = hist_v_q;
        hold_d   = hold_q;
        cap_d    = push;
        seg_d    = '1;

        if (sync_q != prev_q) begin
            prev_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_W'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            acc_d   = sync_q;
            code_d  = enc;
            valid_d = |sync_q;
        end

        if (bus.clear) begin
            hist_v_d = '0;
            hold_d   = '0;
        end else if (push) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--) begin
                hist_d[k] = hist_q[k-1];
            end
            hist_d[0] = enc;
            hist_v_d  = NUM_DIGITS'({hist_v_q, 1'b1});
            hold_d    = HOLD_W'(HOLD_CYC);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_d[DIG_W*k+1 +: 7] = hist_v_q[k] ? glyph[k] : SEG_BLANK;
        end
        seg_d[0] = (hold_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hist_q   <= '0;
            hist_v_q <= '0;
            hold_q   <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            cap_q    <= 1'b0;
            seg_q    <= '1;
        end else begin
            sync1_q  <= bus.data_in;
            sync_q   <= sync1_q;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            hist_v_q <= hist_v_d;
            hold_q   <= hold_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            cap_q    <= cap_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.code      = code_q;
    assign bus.valid     = valid_q;
    assign bus.cap_pulse = cap_q;

endmodule
